lab4_net_adaptive_input_ctrl: RTL and testbench

Stateful input-port controller for a ring router's terminal and channel inputs. It computes the output-port request for the head message, holds that request stable until it is granted, and returns a ready to the input queue. It supports a greedy mode and an adaptive mode: in adaptive mode, equidistant destinations pick a direction from downstream credit counts with a fair tie-break, and a starved equidistant request can re-route. It sits between the input queue and the router's per-output arbiters.

---
 rtl/lab4_net_pkg.sv | 25 ++
 rtl/lab4_net_RingRouteCompute.sv | 59 +++++
 rtl/lab4_net_adaptive_input_ctrl.sv | 132 +++++++++++++
 tb/tb_lab4_net_adaptive_input_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lab4_net_pkg.sv
// Shared definitions for the ring-router input controller: request bit positions, FSM states,
// and a helper that mirrors a directional request onto the opposite ring direction.
package lab4_net_pkg;

  localparam int REQ_WEST  = 0;
  localparam int REQ_TERM  = 1;
  localparam int REQ_EAST  = 2;
  localparam int REQ_NBITS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Swaps west/east; a terminal request maps onto itself.
  function automatic logic [REQ_NBITS-1:0] req_flip(input logic [REQ_NBITS-1:0] r);
    logic [REQ_NBITS-1:0] f;
    f           = '0;
    f[REQ_WEST] = r[REQ_EAST];
    f[REQ_EAST] = r[REQ_WEST];
    f[REQ_TERM] = r[REQ_TERM];
    return f;
  endfunction

endpackage

// File: rtl/lab4_net_RingRouteCompute.sv
// Combinational ring route selection for one head message: shortest direction, with equidistant
// destinations resolved greedily (east) or adaptively from downstream credits and a fair toggle.
module lab4_net_RingRouteCompute
  import lab4_net_pkg::*;
#(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  localparam int c_dest_nbits    = $clog2(p_num_routers)
) (
  input  logic [c_dest_nbits-1:0]     dest,
  input  logic [p_num_free_nbits-1:0] num_free_west,
  input  logic [p_num_free_nbits-1:0] num_free_east,
  input  logic                        tie_tgl,
  input  logic                        mode,
  output logic [REQ_NBITS-1:0]        route,
  output logic                        tie,
  output logic                        tie_brk
);

  localparam logic [c_dest_nbits-1:0] c_id = c_dest_nbits'(p_router_id);

  logic [c_dest_nbits-1:0] dist_east;
  logic [c_dest_nbits-1:0] dist_west;

  // Both distances wrap modulo the ring size through the natural width of the subtraction.
  assign dist_east = dest - c_id;
  assign dist_west = c_id - dest;

  always_comb begin
    route   = '0;
    tie     = 1'b0;
    tie_brk = 1'b0;
    if (dest == c_id) begin
      route[REQ_TERM] = 1'b1;
    end else if (dist_east < dist_west) begin
      route[REQ_EAST] = 1'b1;
    end else if (dist_west < dist_east) begin
      route[REQ_WEST] = 1'b1;
    end else begin
      tie = 1'b1;
      if (!mode) begin
        route[REQ_EAST] = 1'b1;
      end else if (num_free_west > num_free_east) begin
        route[REQ_WEST] = 1'b1;
      end else if (num_free_east > num_free_west) begin
        route[REQ_EAST] = 1'b1;
      end else begin
        tie_brk = 1'b1;
        if (tie_tgl) begin
          route[REQ_WEST] = 1'b1;
        end else begin
          route[REQ_EAST] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lab4_net_adaptive_input_ctrl.sv
// Input-port controller: requests an output for the head message, holds it until granted, dequeues
// in the grant cycle (zero latency); a starved adaptive tie request re-routes after p_stall_limit cycles.
module lab4_net_adaptive_input_ctrl
  import lab4_net_pkg::*;
#(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  parameter int p_adaptive       = 1,
  parameter int p_stall_limit    = 4,
  localparam int c_dest_nbits    = $clog2(p_num_routers)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_dest_nbits-1:0]     dest,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_num_free_nbits-1:0] num_free_west,
  input  logic [p_num_free_nbits-1:0] num_free_east,
  output logic [REQ_NBITS-1:0]        reqs,
  input  logic [REQ_NBITS-1:0]        grants
);

  localparam int                       c_stall_nbits = $clog2(p_stall_limit + 1);
  localparam logic [c_stall_nbits-1:0] c_stall_max   = c_stall_nbits'(p_stall_limit);
  localparam logic [c_stall_nbits-1:0] c_stall_one   = c_stall_nbits'(1);
  localparam logic                     c_mode        = (p_adaptive != 0);

  state_t                     state_q, state_d;
  logic [REQ_NBITS-1:0]       route_q, route_d;
  logic                       tie_q, tie_d;
  logic                       tbrk_q, tbrk_d;
  logic [c_stall_nbits-1:0]   stall_cnt_q, stall_cnt_d;
  logic                       tie_tgl_q, tie_tgl_d;

  logic [REQ_NBITS-1:0]       route_c;
  logic                       tie_c;
  logic                       tbrk_c;
  logic [REQ_NBITS-1:0]       reqs_c;
  logic                       granted;
  logic [p_num_free_nbits-1:0] opp_free;
  logic                       reroute;

  lab4_net_RingRouteCompute #(
    .p_router_id      (p_router_id),
    .p_num_routers    (p_num_routers),
    .p_num_free_nbits (p_num_free_nbits)
  ) u_route (
    .dest          (dest),
    .num_free_west (num_free_west),
    .num_free_east (num_free_east),
    .tie_tgl       (tie_tgl_q),
    .mode          (c_mode),
    .route         (route_c),
    .tie           (tie_c),
    .tie_brk       (tbrk_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      route_q     <= '0;
      tie_q       <= 1'b0;
      tbrk_q      <= 1'b0;
      stall_cnt_q <= '0;
      tie_tgl_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      tie_q       <= tie_d;
      tbrk_q      <= tbrk_d;
      stall_cnt_q <= stall_cnt_d;
      tie_tgl_q   <= tie_tgl_d;
    end
  end

  // Outputs are gated by reset so a held request cannot leak while reset is asserted.
  always_comb begin
    reqs_c = '0;
    if (!reset && in_val) begin
      reqs_c = (state_q == HOLD) ? route_q : route_c;
    end
    granted = ((grants & reqs_c) == reqs_c);
    in_rdy  = in_val && (reqs_c != '0) && granted;
    reqs    = reqs_c;
  end

  always_comb begin
    opp_free = route_q[REQ_EAST] ? num_free_west : num_free_east;
    reroute  = c_mode && tie_q && (stall_cnt_q == c_stall_max) && (opp_free != '0);
  end

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    tie_d       = tie_q;
    tbrk_d      = tbrk_q;
    stall_cnt_d = stall_cnt_q;
    tie_tgl_d   = tie_tgl_q;
    case (state_q)
      IDLE: begin
        if (in_val && !granted) begin
          state_d     = HOLD;
          route_d     = route_c;
          tie_d       = tie_c;
          tbrk_d      = tbrk_c;
          stall_cnt_d = c_stall_one;
        end
      end
      HOLD: begin
        if (!in_val || granted) begin
          state_d     = IDLE;
          route_d     = '0;
          tie_d       = 1'b0;
          tbrk_d      = 1'b0;
          stall_cnt_d = '0;
        end else if (reroute) begin
          // Once flipped, the route no longer reflects the equal-count tie-break.
          route_d     = req_flip(route_q);
          tbrk_d      = 1'b0;
          stall_cnt_d = '0;
        end else if (stall_cnt_q != c_stall_max) begin
          stall_cnt_d = stall_cnt_q + c_stall_one;
        end
      end
    endcase
    if (in_rdy && ((state_q == IDLE) ? tbrk_c : tbrk_q)) begin
      tie_tgl_d = ~tie_tgl_q;
    end
  end

endmodule

// File: tb/tb_lab4_net_adaptive_input_ctrl.sv
// Directed bench for the ring input controller: an adaptive and a greedy instance (N=8, id=2)
// share stimulus; expected adaptive outputs go through a scoreboard queue.
module tb_lab4_net_adaptive_input_ctrl;
  import lab4_net_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] dest;
  logic       in_val;
  logic [1:0] nf_w;
  logic [1:0] nf_e;
  logic [2:0] grants;
  logic [2:0] reqs_a, reqs_g;
  logic       rdy_a, rdy_g;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [2:0] r;
    logic       rdy;
  } sb_item_t;

  sb_item_t sb[$];

  lab4_net_adaptive_input_ctrl #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2), .p_adaptive(1), .p_stall_limit(4)
  ) u_a (
    .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy_a),
    .num_free_west(nf_w), .num_free_east(nf_e), .reqs(reqs_a), .grants(grants)
  );

  lab4_net_adaptive_input_ctrl #(
    .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2), .p_adaptive(0), .p_stall_limit(4)
  ) u_g (
    .clk(clk), .reset(reset), .dest(dest), .in_val(in_val), .in_rdy(rdy_g),
    .num_free_west(nf_w), .num_free_east(nf_e), .reqs(reqs_g), .grants(grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [2:0] r, input logic rdy);
    sb_item_t it;
    it.tag = tag;
    it.r   = r;
    it.rdy = rdy;
    sb.push_back(it);
  endtask

  task automatic sample_a();
    sb_item_t it;
    it = sb.pop_front();
    chk({it.tag, ".reqs"}, 32'(reqs_a), 32'(it.r));
    chk({it.tag, ".rdy"}, 32'(rdy_a), 32'(it.rdy));
  endtask

  task automatic apply(input logic [2:0] d, input logic v, input logic [2:0] g,
                       input logic [1:0] w, input logic [1:0] e);
    dest   = d;
    in_val = v;
    grants = g;
    nf_w   = w;
    nf_e   = e;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    in_val = 1'b0;
    dest   = '0;
    grants = '0;
    nf_w   = '0;
    nf_e   = '0;
    #2;
    expect_a("reset", 3'b000, 1'b0);
    sample_a();
    chk("reset.stall", 32'(u_a.stall_cnt_q), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    apply(3'd2, 1'b1, 3'b010, 2'd0, 2'd0);
    expect_a("term", 3'b010, 1'b1);
    sample_a();
    tick();
    chk("term.state", 32'(u_a.state_q), 32'(IDLE));

    apply(3'd4, 1'b1, 3'b100, 2'd0, 2'd0);
    expect_a("east", 3'b100, 1'b1);
    sample_a();
    tick();
    apply(3'd0, 1'b1, 3'b001, 2'd0, 2'd0);
    expect_a("west", 3'b001, 1'b1);
    sample_a();
    chk("west.greedy", 32'(reqs_g), 32'(3'b001));
    tick();

    // Three withheld cycles; dest and credits change meanwhile but must be ignored.
    apply(3'd4, 1'b1, 3'b000, 2'd1, 2'd1);
    expect_a("hold0", 3'b100, 1'b0);
    sample_a();
    tick();
    for (int k = 1; k < 3; k++) begin
      apply(3'd0, 1'b1, 3'b000, 2'd3, 2'd0);
      expect_a($sformatf("hold%0d", k), 3'b100, 1'b0);
      sample_a();
      tick();
    end
    apply(3'd0, 1'b1, 3'b100, 2'd3, 2'd0);
    expect_a("hold.grant", 3'b100, 1'b1);
    sample_a();
    tick();
    apply(3'd0, 1'b0, 3'b000, 2'd0, 2'd0);
    expect_a("idle", 3'b000, 1'b0);
    sample_a();
    chk("idle.greedy", 32'(reqs_g), 32'd0);
    tick();

    apply(3'd6, 1'b1, 3'b111, 2'd2, 2'd1);
    expect_a("tie.adaptive", 3'b001, 1'b1);
    sample_a();
    chk("tie.greedy.reqs", 32'(reqs_g), 32'(3'b100));
    chk("tie.greedy.rdy", 32'(rdy_g), 32'd1);
    tick();

    apply(3'd6, 1'b1, 3'b111, 2'd3, 2'd3);
    expect_a("tgl.first", 3'b100, 1'b1);
    sample_a();
    tick();
    apply(3'd6, 1'b1, 3'b111, 2'd3, 2'd3);
    expect_a("tgl.second", 3'b001, 1'b1);
    sample_a();
    tick();

    // Toggle is back at 0, so this tie starts east and is then starved.
    for (int k = 0; k < 5; k++) begin
      apply(3'd6, 1'b1, 3'b000, 2'd1, 2'd1);
      expect_a($sformatf("starve%0d", k), 3'b100, 1'b0);
      sample_a();
      chk($sformatf("starve%0d.stall", k), 32'(u_a.stall_cnt_q), 32'(k));
      tick();
    end
    apply(3'd6, 1'b1, 3'b000, 2'd1, 2'd1);
    expect_a("reroute", 3'b001, 1'b0);
    sample_a();
    chk("reroute.stall", 32'(u_a.stall_cnt_q), 32'd0);
    chk("reroute.greedy", 32'(reqs_g), 32'(3'b100));
    tick();
    apply(3'd6, 1'b1, 3'b001, 2'd1, 2'd1);
    expect_a("reroute.grant", 3'b001, 1'b1);
    sample_a();
    tick();

    for (int k = 0; k < 8; k++) begin
      apply(3'd4, 1'b1, 3'b000, 2'd1, 2'd1);
      expect_a($sformatf("noflip%0d", k), 3'b100, 1'b0);
      sample_a();
      tick();
    end

    reset = 1'b1;
    #1;
    expect_a("rst.hold", 3'b000, 1'b0);
    sample_a();
    chk("rst.hold.greedy", 32'(reqs_g), 32'd0);
    chk("rst.hold.state", 32'(u_a.state_q), 32'(IDLE));
    tick();
    tick();
    reset = 1'b0;
    apply(3'd3, 1'b1, 3'b100, 2'd1, 2'd1);
    expect_a("post.rst", 3'b100, 1'b1);
    sample_a();
    tick();
    chk("post.rst.state", 32'(u_a.state_q), 32'(IDLE));

    in_val = 1'b0;
    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
